// File: rtl/partition_sweep_checker.sv
// Exhaustive sweep of an NI-input partition comparing exact vs approximate responses.
// Define PARTITION_SWEEP_ABS_ERR_EN to build the absolute-difference accumulator.
module partition_sweep_checker #(
    parameter int NI     = 7,
    parameter int NO     = 4,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic [NI-1:0]    pi,
    input  logic [NO-1:0]    po_exact,
    input  logic [NO-1:0]    po_approx,
    output logic             busy,
    output logic             done,
    output logic [NI:0]      err_count,
    output logic [NI+3:0]    ham_total,
    output logic [NI+NO-1:0] abs_err_sum,
    output logic [NI-1:0]    first_fail_vec,
    output logic             first_fail_valid
);

    localparam int HW = NI + 4;

    function automatic logic [HW-1:0] popcount(input logic [NO-1:0] x);
        logic [HW-1:0] n;
        n = '0;
        for (int i = 0; i < NO; i++) n = n + HW'(x[i]);
        return n;
    endfunction

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    // With no settle cycles DRIVE is skipped so each vector still takes SETTLE+1 cycles.
    localparam state_t VEC_ENTRY = (SETTLE == 0) ? SAMPLE : DRIVE;

    state_t         state_q, state_d;
    logic [3:0]     settle_q, settle_d;
    logic [NI-1:0]  pi_q, pi_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic [NI:0]    err_q, err_d;
    logic [HW-1:0]  ham_q, ham_d;
    logic [NI-1:0]  ffv_q, ffv_d;
    logic           ffvalid_q, ffvalid_d;
    logic           mismatch;

`ifdef PARTITION_SWEEP_ABS_ERR_EN
    logic [NI+NO-1:0] abs_q, abs_d;
    logic [NO:0]      diff;
    logic [NO-1:0]    abs_diff;

    always_comb begin
        diff     = {1'b0, po_exact} - {1'b0, po_approx};
        abs_diff = diff[NO] ? NO'(~diff + (NO+1)'(1)) : NO'(diff);
    end
`endif

    assign mismatch = (po_exact != po_approx);

    always_comb begin
        state_d   = state_q;
        settle_d  = settle_q;
        pi_d      = pi_q;
        busy_d    = busy_q;
        done_d    = done_q;
        err_d     = err_q;
        ham_d     = ham_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;
`ifdef PARTITION_SWEEP_ABS_ERR_EN
        abs_d     = abs_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = VEC_ENTRY;
                    settle_d  = '0;
                    pi_d      = '0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    err_d     = '0;
                    ham_d     = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
`ifdef PARTITION_SWEEP_ABS_ERR_EN
                    abs_d     = '0;
`endif
                end
            end
            DRIVE: begin
                settle_d = settle_q + 4'd1;
                if (settle_q == 4'(SETTLE - 1)) state_d = SAMPLE;
            end
            SAMPLE: begin
                if (mismatch) begin
                    err_d = err_q + (NI+1)'(1);
                    ham_d = ham_q + popcount(po_exact ^ po_approx);
                    if (!ffvalid_q) begin
                        ffv_d     = pi_q;
                        ffvalid_d = 1'b1;
                    end
                end
`ifdef PARTITION_SWEEP_ABS_ERR_EN
                abs_d = abs_q + (NI+NO)'(abs_diff);
`endif
                if (pi_q == {NI{1'b1}}) begin
                    state_d = DONE;
                    pi_d    = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d  = VEC_ENTRY;
                    pi_d     = pi_q + NI'(1);
                    settle_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            settle_q  <= '0;
            pi_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= '0;
            ham_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
`ifdef PARTITION_SWEEP_ABS_ERR_EN
            abs_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            settle_q  <= settle_d;
            pi_q      <= pi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ham_q     <= ham_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
`ifdef PARTITION_SWEEP_ABS_ERR_EN
            abs_q     <= abs_d;
`endif
        end
    end

    assign pi               = pi_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err_count        = err_q;
    assign ham_total        = ham_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;
`ifdef PARTITION_SWEEP_ABS_ERR_EN
    assign abs_err_sum      = abs_q;
`else
    assign abs_err_sum      = '0;
`endif

endmodule

// File: tb/tb_partition_sweep_checker.sv
// Scoreboard bench for partition_sweep_checker (NI=7, NO=4, SETTLE=1); models the two partitions.
module tb_partition_sweep_checker;

    typedef struct {
        int err;
        int ham;
        int abs;
        int ffv;
        int ffvalid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [6:0]  pi;
    logic [3:0]  poExact, poApprox;
    logic        busy, done;
    logic [7:0]  errCount;
    logic [10:0] hamTotal;
    logic [10:0] absErrSum;
    logic [6:0]  firstFailVec;
    logic        firstFailValid;

    int          mode;
    logic [3:0]  randTab [128];
    exp_t        sb [$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    partition_sweep_checker #(.NI(7), .NO(4), .SETTLE(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pi(pi),
        .po_exact(poExact), .po_approx(poApprox),
        .busy(busy), .done(done), .err_count(errCount), .ham_total(hamTotal),
        .abs_err_sum(absErrSum), .first_fail_vec(firstFailVec),
        .first_fail_valid(firstFailValid)
    );

    function automatic logic [3:0] exactOut(input int m, input logic [6:0] v);
        logic [3:0] b;
        b = v[3:0] + {1'b0, v[6:4]};
        if (m == 2 && v == 7'd100) b = 4'b1011;
        return b;
    endfunction

    function automatic logic [3:0] approxOut(input int m, input logic [6:0] v);
        case (m)
            0:       return exactOut(m, v);
            1:       return exactOut(m, v) ^ 4'b0001;
            2:       return (v == 7'd100) ? 4'b0000 : exactOut(m, v);
            default: return randTab[v];
        endcase
    endfunction

    // Both partitions respond combinationally to the vector the DUT drives.
    always_comb begin
        poExact  = exactOut(mode, pi);
        poApprox = approxOut(mode, pi);
    end

    function automatic exp_t computeExp(input int m);
        exp_t x;
        logic [3:0] e, a;
        x = '{default: 0};
        for (int v = 0; v < 128; v++) begin
            e = exactOut(m, 7'(v));
            a = approxOut(m, 7'(v));
            if (e != a) begin
                x.err++;
                x.ham += $countones(e ^ a);
                if (x.ffvalid == 0) begin
                    x.ffvalid = 1;
                    x.ffv = v;
                end
            end
`ifdef PARTITION_SWEEP_ABS_ERR_EN
            x.abs += (e > a) ? int'(e - a) : int'(a - e);
`endif
        end
        return x;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_pi"}, 32'(pi), 0);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_err"}, 32'(errCount), 0);
        checkOutput({tag, "_ham"}, 32'(hamTotal), 0);
        checkOutput({tag, "_abs"}, 32'(absErrSum), 0);
        checkOutput({tag, "_ffv"}, 32'(firstFailVec), 0);
        checkOutput({tag, "_ffvalid"}, 32'(firstFailValid), 0);
    endtask

    task automatic applyStimulus(input int m);
        mode  = m;
        start = 1'b1;
        sb.push_back(computeExp(m));
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("busy_rise", 32'(busy), 1);
        checkOutput("done_clear", 32'(done), 0);
    endtask

    task automatic waitDone(input bit pulse, input int resetAt);
        int c;
        exp_t x;
        c = 0;
        forever begin
            if (c == resetAt) begin
                rst_n = 1'b0;
                #1;
                checkAllZero("rst_mid");
                if (sb.size() > 0) x = sb.pop_front();
                #2;
                rst_n = 1'b1;
                return;
            end
            if (done === 1'b1) begin
                checkOutput("sweep_len", c, 256);
                checkOutput("end_pi", 32'(pi), 0);
                checkOutput("end_busy", 32'(busy), 0);
                if (sb.size() == 0) begin
                    checkOutput("sb_underflow", 0, 1);
                    return;
                end
                x = sb.pop_front();
                checkOutput("err_count", 32'(errCount), x.err);
                checkOutput("ham_total", 32'(hamTotal), x.ham);
                checkOutput("abs_err_sum", 32'(absErrSum), x.abs);
                checkOutput("ff_valid", 32'(firstFailValid), x.ffvalid);
                if (x.ffvalid != 0) checkOutput("ff_vec", 32'(firstFailVec), x.ffv);
                return;
            end
            if (c > 600) begin
                checkOutput("timeout", c, 256);
                if (sb.size() > 0) x = sb.pop_front();
                return;
            end
            if (c % 50 == 3) checkOutput("pi_seq", 32'(pi), c / 2);
            if (c == 50) checkOutput("busy_hold", 32'(busy), 1);
            start = pulse && (c == 10 || c == 100);
            @(posedge clk); #1;
            start = 1'b0;
            c++;
        end
    endtask

    initial begin
        exp_t e2;
        for (int i = 0; i < 128; i++) randTab[i] = 4'($urandom_range(0, 15));
        rst_n = 1'b0;
        start = 1'b0;
        mode  = 0;
        #22;
        checkAllZero("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        applyStimulus(0); waitDone(1'b0, -1);
        applyStimulus(1); waitDone(1'b0, -1);
        applyStimulus(2); waitDone(1'b0, -1);

        e2 = computeExp(2);
        repeat (3) @(posedge clk);
        #1;
        checkOutput("done_sticky", 32'(done), 1);
        checkOutput("err_hold", 32'(errCount), e2.err);

        applyStimulus(3); waitDone(1'b0, -1);
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(1); waitDone(1'b1, -1);
        applyStimulus(1); waitDone(1'b0, 100);
        @(posedge clk); #1;
        checkOutput("no_resume", 32'(busy), 0);
        checkOutput("no_resume_pi", 32'(pi), 0);
        applyStimulus(1); waitDone(1'b0, -1);

        checkOutput("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/partition_sweep_checker.md
# partition_sweep_checker

Sequential exhaustive-sweep engine for the partition evaluation flow. It drives every input vector of an `NI`-input partition and captures the `NO`-bit responses of the exact and approximate partition netlists, which are instantiated side by side. It accumulates error metrics in hardware, so no per-vector `$display` dumps are needed. It sits upstream of the partition under test, feeding `pi`, and downstream of it, consuming `po_exact` and `po_approx`. Its results feed the design-space-exploration scoring logic.

## Interface
Parameters:
- `NI`, default 7: partition input count; sweep length is 2^NI vectors; legal range 1..16.
- `NO`, default 4: partition output count; legal range 1..8.
- `SETTLE`, default 1: extra cycles each vector is held before sampling; legal range 0..15.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `start`, input, 1: one-cycle request to begin a sweep; honoured only in IDLE or DONE.
- `pi`, output, NI: vector driven to both partitions (registered).
- `po_exact`, input, NO: response of the exact partition.
- `po_approx`, input, NO: response of the approximate partition.
- `busy`, output, 1: sweep in progress.
- `done`, output, 1: sticky; high once the sweep completes, until the next accepted `start` or reset.
- `err_count`, output, NI+1: number of vectors where `po_exact` != `po_approx`.
- `ham_total`, output, NI+4: sum over all vectors of popcount(`po_exact` ^ `po_approx`).
- `abs_err_sum`, output, NI+NO: sum of |`po_exact` − `po_approx`| (unsigned); active only with the macro.
- `first_fail_vec`, output, NI: first vector that mismatched.
- `first_fail_valid`, output, 1: `first_fail_vec` is meaningful.

## Operation
- States: IDLE, DRIVE, SAMPLE, DONE.
- **Start.** IDLE/DONE + `start`=1 → DRIVE. On that edge:
  - clear all accumulators, `first_fail_valid` and `done`;
  - set `pi`=0, a settle counter to 0, and `busy`=1.
- **DRIVE.** Holds `pi`. The settle counter increments each cycle; the FSM goes to SAMPLE when the counter reaches `SETTLE`. With `SETTLE`=0 it goes to SAMPLE on the next edge.
- **SAMPLE.** Compares `po_exact` and `po_approx` in this cycle. On the edge leaving SAMPLE:
  - if the outputs differ: `err_count`+=1 and `ham_total`+=popcount;
  - `abs_err_sum`+=|diff| (macro only);
  - on the first mismatch of the sweep, latch `first_fail_vec`=`pi` and set `first_fail_valid`=1.
- **Next vector.** If `pi` < 2^NI−1: `pi`+=1 and go to DRIVE with the settle counter at 0. Otherwise go to DONE with `pi`=0, `busy`=0 and `done`=1.
- **DONE.** Results hold until a new `start` or reset.
- **Arithmetic.** All sums are unsigned and zero-extended to the accumulator width. The widths are sized so none can overflow:
  - `err_count` ≤ 2^NI;
  - `ham_total` ≤ 8·2^NI;
  - `abs_err_sum` ≤ (2^NO−1)·2^NI.
- `start` during DRIVE/SAMPLE is ignored: no restart and no effect on the accumulators.
- **Reset.** `rst_n` low, including mid-sweep, immediately forces IDLE and sets every output to 0: `pi`, `busy`, `done`, all accumulators, `first_fail_vec` and `first_fail_valid`. There is no resume; a new `start` is required.

## Timing
- Every vector occupies exactly `SETTLE`+1 cycles; `SETTLE` cycles are in DRIVE and the final cycle is SAMPLE.
- `busy` rises on the edge that samples `start`=1.
- `done` rises and `busy` falls on the same edge, exactly 2^NI·(`SETTLE`+1) edges after `busy` rose. For NI=7 and `SETTLE`=1 this is 256 cycles.
- Accumulators update one edge after each SAMPLE cycle. Final values are valid in the first cycle `done`=1.
- The partitions must settle combinationally within `SETTLE`+1 cycles of a `pi` change.
- Back-to-back sweeps: `start` in the first DONE cycle re-enters DRIVE on the next edge. On that edge `done` drops and `busy` rises.

## Configuration
- Macro: `PARTITION_SWEEP_ABS_ERR_EN`.
- **Defined:** the absolute-difference accumulator is built. It uses a NO+1-bit signed subtract with magnitude, feeding an NI+NO-bit adder, and `abs_err_sum` reports the mean-error numerator.
- **Undefined:** no subtractor or accumulator is synthesised and `abs_err_sum` is tied to 0. All other behaviour and timing are identical.

## Test plan
All scenarios use NI=7, NO=4, `SETTLE`=1, with the macro defined unless noted.
- **Identical outputs.** `po_approx`=`po_exact`=pi[3:0]+pi[6:4] → `done` 256 cycles after `busy` rises, with:
  - `err_count`=0, `ham_total`=0, `abs_err_sum`=0;
  - `first_fail_valid`=0 and `pi`=0.
- **LSB flip.** `po_approx`=`po_exact`^4'b0001 → `err_count`=128, `ham_total`=128, `abs_err_sum`=128, `first_fail_vec`=0, `first_fail_valid`=1.
- **Single-vector fault.** `po_approx` differs only at pi=7'd100 (exact 4'b1011, approx 4'b0000) → `err_count`=1, `ham_total`=3, `abs_err_sum`=11, `first_fail_vec`=100.
- **Start while busy.** Pulse `start` at cycles 10 and 100 after the first accepted start → the sweep still completes at cycle 256 with results identical to the undisturbed run.
- **Reset mid-sweep.** Assert `rst_n`=0 at vector 50 → all outputs are 0 immediately. Then release and `start` → a full, correct sweep.
- **Macro undefined.** Repeat the LSB-flip scenario → `abs_err_sum`=0, all other results unchanged.
